// File: rtl/mem_access.sv
`default_nettype none
// mem_access: memory pipeline stage that issues data-memory requests and waits a bounded time for ready.
// State updates on the falling edge of clk; rstd clears the stage asynchronously.
module mem_access #(
  parameter int MAX_WAIT = 15
) (
  input  logic        clk,
  input  logic        rstd,
  input  logic [31:0] EM_pc,
  input  logic [31:0] EM_alu_result,
  input  logic [31:0] EM_w_data,
  input  logic [1:0]  EM_mem_access_width,
  input  logic [4:0]  EM_rd_addr,
  input  logic        EM_w_enable,
  input  logic        EM_is_store,
  input  logic        EM_is_load,
  input  logic        EM_is_load_unsigned,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [3:0]  dmem_be,
  output logic [31:0] dmem_wdata,
  input  logic        dmem_ready,
  input  logic [31:0] dmem_rdata,
  output logic        mem_stall,
  output logic        mem_fault,
  output logic [31:0] MW_pc,
  output logic [31:0] MW_w_data,
  output logic [4:0]  MW_rd_addr,
  output logic        MW_w_enable
);
  localparam int            CW         = $clog2(MAX_WAIT + 1);
  localparam logic [CW-1:0] WAIT_LIMIT = CW'(MAX_WAIT);

  typedef enum logic [0:0] {S_IDLE = 1'b0, S_WAIT = 1'b1} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;

  // Access held stable while the memory has not yet answered
  logic [31:0] addr_q, wdata_q, pc_q;
  logic [3:0]  be_q;
  logic [1:0]  width_q;
  logic [4:0]  rd_q;
  logic        we_q, uns_q, wen_q;
  logic        capture;

  logic [31:0] mw_pc_q, mw_pc_d, mw_data_q, mw_data_d;
  logic [4:0]  mw_rd_q, mw_rd_d;
  logic        mw_wen_q, mw_wen_d, fault_q, fault_d;

  logic        is_mem, misaligned, req_c, stall_c;
  logic [3:0]  live_be;
  logic [31:0] live_wdata;

  function automatic logic [31:0] load_fmt(input logic [31:0] rdata, input logic [1:0] lane,
                                           input logic [1:0] width, input logic uns);
    logic [7:0]  b;
    logic [15:0] h;
    case (lane)
      2'd0:    b = rdata[7:0];
      2'd1:    b = rdata[15:8];
      2'd2:    b = rdata[23:16];
      default: b = rdata[31:24];
    endcase
    h = lane[1] ? rdata[31:16] : rdata[15:0];
    case (width)
      2'd0:    load_fmt = {{24{b[7] & ~uns}}, b};
      2'd1:    load_fmt = {{16{h[15] & ~uns}}, h};
      default: load_fmt = rdata;
    endcase
  endfunction

  always_comb begin
    is_mem = EM_is_load | EM_is_store;
    case (EM_mem_access_width)
      2'd0:    misaligned = 1'b0;
      2'd1:    misaligned = EM_alu_result[0];
      default: misaligned = |EM_alu_result[1:0];
    endcase
    live_be    = 4'hF;
    live_wdata = EM_w_data;
    if (EM_is_store) begin
      case (EM_mem_access_width)
        2'd0:    live_be = 4'b0001 << EM_alu_result[1:0];
        2'd1:    live_be = 4'b0011 << EM_alu_result[1:0];
        default: live_be = 4'hF;
      endcase
    end
    case (EM_mem_access_width)
      2'd0:    live_wdata = {4{EM_w_data[7:0]}};
      2'd1:    live_wdata = {2{EM_w_data[15:0]}};
      default: live_wdata = EM_w_data;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    capture   = 1'b0;
    req_c     = 1'b0;
    stall_c   = 1'b0;
    fault_d   = 1'b0;
    mw_pc_d   = mw_pc_q;
    mw_data_d = mw_data_q;
    mw_rd_d   = mw_rd_q;
    mw_wen_d  = mw_wen_q;
    case (state_q)
      S_IDLE: begin
        mw_pc_d   = EM_pc;
        mw_rd_d   = EM_rd_addr;
        mw_data_d = EM_alu_result;
        mw_wen_d  = EM_w_enable & ~EM_is_store;
        if (is_mem && misaligned) begin
          fault_d  = 1'b1;
          mw_wen_d = 1'b0;
        end else if (is_mem) begin
          req_c = 1'b1;
          if (dmem_ready) begin
            if (!EM_is_store)
              mw_data_d = load_fmt(dmem_rdata, EM_alu_result[1:0], EM_mem_access_width,
                                   EM_is_load_unsigned);
          end else begin
            stall_c  = 1'b1;
            capture  = 1'b1;
            state_d  = S_WAIT;
            cnt_d    = CW'(1);
            mw_wen_d = 1'b0;
          end
        end
      end
      S_WAIT: begin
        req_c = 1'b1;
        if (dmem_ready) begin
          state_d   = S_IDLE;
          cnt_d     = '0;
          mw_pc_d   = pc_q;
          mw_rd_d   = rd_q;
          mw_wen_d  = wen_q & ~we_q;
          mw_data_d = we_q ? addr_q : load_fmt(dmem_rdata, addr_q[1:0], width_q, uns_q);
        end else if (cnt_q == WAIT_LIMIT) begin
          // Memory never answered: drop the access and report it
          state_d  = S_IDLE;
          cnt_d    = '0;
          fault_d  = 1'b1;
          mw_wen_d = 1'b0;
        end else begin
          stall_c  = 1'b1;
          cnt_d    = cnt_q + 1'b1;
          mw_wen_d = 1'b0;
        end
      end
    endcase
  end

  // Request and stall are gated by rstd so they fall immediately on reset
  assign dmem_req   = rstd & req_c;
  assign mem_stall  = rstd & stall_c;
  assign dmem_we    = rstd & req_c & ((state_q == S_WAIT) ? we_q : EM_is_store);
  assign dmem_addr  = (state_q == S_WAIT) ? {addr_q[31:2], 2'b00} : {EM_alu_result[31:2], 2'b00};
  assign dmem_be    = (state_q == S_WAIT) ? be_q : live_be;
  assign dmem_wdata = (state_q == S_WAIT) ? wdata_q : live_wdata;

  assign mem_fault   = fault_q;
  assign MW_pc       = mw_pc_q;
  assign MW_w_data   = mw_data_q;
  assign MW_rd_addr  = mw_rd_q;
  assign MW_w_enable = mw_wen_q;

  always_ff @(negedge clk or negedge rstd) begin
    if (!rstd) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      fault_q   <= 1'b0;
      mw_pc_q   <= '0;
      mw_data_q <= '0;
      mw_rd_q   <= '0;
      mw_wen_q  <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      pc_q      <= '0;
      be_q      <= '0;
      width_q   <= '0;
      rd_q      <= '0;
      we_q      <= 1'b0;
      uns_q     <= 1'b0;
      wen_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      fault_q   <= fault_d;
      mw_pc_q   <= mw_pc_d;
      mw_data_q <= mw_data_d;
      mw_rd_q   <= mw_rd_d;
      mw_wen_q  <= mw_wen_d;
      if (capture) begin
        addr_q  <= EM_alu_result;
        wdata_q <= live_wdata;
        pc_q    <= EM_pc;
        be_q    <= live_be;
        width_q <= EM_mem_access_width;
        rd_q    <= EM_rd_addr;
        we_q    <= EM_is_store;
        uns_q   <= EM_is_load_unsigned;
        wen_q   <= EM_w_enable;
      end
    end
  end
endmodule
`default_nettype wire
